// File: rtl/subz1_unpack_stream.sv
// Input zero-point removal: two-stage valid/ready pipeline emitting sign-extended (q1 - z1) lanes.
// Optional define ZERO_MASK_EN adds m_zero_mask flagging lanes where q1 == z1.
module subz1_unpack_stream #(
  parameter int LANES     = 8,
  parameter int OUT_W     = 16,
  parameter int PIX_CNT_W = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             zero_data_in,
  input  logic [PIX_CNT_W-1:0]   frame_len,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [LANES*8-1:0]     s_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [LANES*OUT_W-1:0] m_data,
  output logic                   m_last,
  output logic                   busy
`ifdef ZERO_MASK_EN
  ,
  output logic [LANES-1:0]       m_zero_mask
`endif
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                 state_q, state_d;
  logic [PIX_CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]             zLatch_q, zLatch_d;
  logic [PIX_CNT_W-1:0]   lenLatch_q, lenLatch_d;

  logic                   v1_q;
  logic [LANES*8-1:0]     data1_q;
  logic [7:0]             z1_q;
  logic                   last1_q;

  logic                   v2_q;
  logic [LANES*OUT_W-1:0] data2_q, data2_d;
  logic                   last2_q;

  logic                   s2Open;
  logic                   s1Open;
  logic                   accept;
  logic [7:0]             zUse;
  logic [PIX_CNT_W-1:0]   lenUse;
  logic                   lastBeat;
  logic [8:0]             laneDiff [LANES];

  // S2 can take a beat when empty or draining; S1 likewise when S2 is draining it.
  assign s2Open  = !v2_q || m_ready;
  assign s1Open  = !v1_q || s2Open;
  assign s_ready = !rst && s1Open;
  assign accept  = s_valid && s_ready;

  // The first beat of a frame sees the live zero point and length, later beats the latched copies.
  assign zUse     = (state_q == IDLE) ? zero_data_in : zLatch_q;
  assign lenUse   = (state_q == IDLE) ? frame_len : lenLatch_q;
  assign lastBeat = (lenUse == '0) || (cnt_q == lenUse - PIX_CNT_W'(1));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    zLatch_d   = zLatch_q;
    lenLatch_d = lenLatch_q;
    if (accept) begin
      if (state_q == IDLE) begin
        zLatch_d   = zero_data_in;
        lenLatch_d = frame_len;
      end
      if (lastBeat) begin
        cnt_d   = '0;
        state_d = IDLE;
      end else begin
        cnt_d   = cnt_q + PIX_CNT_W'(1);
        state_d = RUN;
      end
    end
  end

  // 9-bit difference covers -255..+255; the signed cast sign-extends into the output lane.
  always_comb begin
    data2_d = '0;
    for (int i = 0; i < LANES; i++) begin
      laneDiff[i] = {1'b0, data1_q[8*i +: 8]} - {1'b0, z1_q};
      data2_d[OUT_W*i +: OUT_W] = OUT_W'($signed(laneDiff[i]));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      zLatch_q   <= '0;
      lenLatch_q <= '0;
      v1_q       <= 1'b0;
      data1_q    <= '0;
      z1_q       <= '0;
      last1_q    <= 1'b0;
      v2_q       <= 1'b0;
      data2_q    <= '0;
      last2_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      zLatch_q   <= zLatch_d;
      lenLatch_q <= lenLatch_d;
      if (s1Open) begin
        v1_q <= s_valid;
        if (s_valid) begin
          data1_q <= s_data;
          z1_q    <= zUse;
          last1_q <= lastBeat;
        end
      end
      if (s2Open) begin
        v2_q <= v1_q;
        if (v1_q) begin
          data2_q <= data2_d;
          last2_q <= last1_q;
        end
      end
    end
  end

`ifdef ZERO_MASK_EN
  logic [LANES-1:0] mask_q, mask_d;

  always_comb begin
    mask_d = '0;
    for (int i = 0; i < LANES; i++) begin
      mask_d[i] = (data1_q[8*i +: 8] == z1_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q <= '0;
    end else if (s2Open && v1_q) begin
      mask_q <= mask_d;
    end
  end

  assign m_zero_mask = mask_q;
`endif

  assign m_valid = v2_q;
  assign m_data  = data2_q;
  assign m_last  = last2_q;
  assign busy    = !rst && ((state_q == RUN) || v1_q || v2_q);

endmodule

// File: tb/tb_subz1_unpack_stream.sv
// Directed self-checking bench for subz1_unpack_stream: latency, stalls, z latching, framing, reset.
// Define ZERO_MASK_EN to also exercise the zero-lane mask.
module tb_subz1_unpack_stream;
  localparam int LANES = 8;
  localparam int OUT_W = 16;
  localparam int PCW   = 20;
  localparam int DW    = LANES * 8;
  localparam int MW    = LANES * OUT_W;

  logic           clk;
  logic           rst;
  logic [7:0]     zero_data_in;
  logic [PCW-1:0] frame_len;
  logic           s_valid;
  logic           s_ready;
  logic [DW-1:0]  s_data;
  logic           m_valid;
  logic           m_ready;
  logic [MW-1:0]  m_data;
  logic           m_last;
  logic           busy;
`ifdef ZERO_MASK_EN
  logic [LANES-1:0] m_zero_mask;
`endif

  int total = 0;
  int bad   = 0;
  int cycle = 0;
  logic toggleEn = 1'b0;
  logic prevStall = 1'b0;
  logic [MW-1:0] prevData = '0;

  logic [MW:0] outQ[$];
  logic [MW:0] expQ[$];
  int          tsQ[$];

  subz1_unpack_stream #(.LANES(LANES), .OUT_W(OUT_W), .PIX_CNT_W(PCW)) dut (
    .clk          (clk),
    .rst          (rst),
    .zero_data_in (zero_data_in),
    .frame_len    (frame_len),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_last       (m_last),
    .busy         (busy)
`ifdef ZERO_MASK_EN
    ,
    .m_zero_mask  (m_zero_mask)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  always @(negedge clk) begin
    if (toggleEn) m_ready = ~m_ready;
  end

  task automatic checkOutput(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Output monitor: records transfers and checks hold-while-stalled behaviour.
  always @(negedge clk) begin
    #1;
    if (rst) begin
      prevStall <= 1'b0;
    end else begin
      if (prevStall) begin
        checkOutput("stallValid", MW'(m_valid), MW'(1));
        checkOutput("stallHold", m_data, prevData);
      end
      if (!s_ready) checkOutput("sreadyLow", MW'({m_valid, m_ready}), MW'(2'b10));
      if (m_valid && m_ready) begin
        outQ.push_back({m_last, m_data});
        tsQ.push_back(cycle);
      end
      prevStall <= m_valid && !m_ready;
      prevData  <= m_data;
    end
  end

  function automatic logic [DW-1:0] mkData(input logic [7:0] q0);
    logic [DW-1:0] d;
    for (int i = 0; i < LANES; i++) d[8*i +: 8] = q0 + 8'(37 * i);
    return d;
  endfunction

  function automatic logic [MW-1:0] expData(input logic [DW-1:0] d, input logic [7:0] z);
    logic [MW-1:0] r;
    logic signed [9:0] t;
    for (int i = 0; i < LANES; i++) begin
      t = $signed({2'b00, d[8*i +: 8]}) - $signed({2'b00, z});
      r[OUT_W*i +: OUT_W] = OUT_W'(t);
    end
    return r;
  endfunction

  task automatic sendRaw(input logic [DW-1:0] d);
    bit done = 0;
    s_valid = 1'b1;
    s_data  = d;
    for (int tries = 0; tries < 50 && !done; tries++) begin
      #1;
      if (s_ready) done = 1;
      @(negedge clk);
    end
    if (!done) checkOutput("sendTimeout", MW'(0), MW'(1));
  endtask

  task automatic applyStimulus(input logic [7:0] q0, input logic [7:0] z, input logic last);
    expQ.push_back({last, expData(mkData(q0), z)});
    sendRaw(mkData(q0));
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drainCheck(input string tag);
    int waited = 0;
    while (outQ.size() < expQ.size() && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    repeat (4) @(negedge clk);
    checkOutput($sformatf("%s_count", tag), MW'(outQ.size()), MW'(expQ.size()));
    for (int k = 0; k < expQ.size(); k++) begin
      checkOutput($sformatf("%s_data%0d", tag, k), outQ[k][MW-1:0], expQ[k][MW-1:0]);
      checkOutput($sformatf("%s_last%0d", tag, k), MW'(outQ[k][MW]), MW'(expQ[k][MW]));
    end
  endtask

  task automatic clearQ();
    outQ.delete();
    expQ.delete();
    tsQ.delete();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, bad=%0d", bad + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    s_valid = 1'b0;
    s_data = '0;
    m_ready = 1'b1;
    zero_data_in = 8'd0;
    frame_len = '0;
    repeat (3) @(negedge clk);
    checkOutput("rstSready", MW'(s_ready), MW'(0));
    checkOutput("rstMvalid", MW'(m_valid), MW'(0));
    checkOutput("rstMlast", MW'(m_last), MW'(0));
    checkOutput("rstMdata", m_data, MW'(0));
    checkOutput("rstBusy", MW'(busy), MW'(0));
    rst = 1'b0;
    #1;
    checkOutput("postRstSready", MW'(s_ready), MW'(1));
    @(negedge clk);

    // Frame of 4 with z=128, lane0 hand values, 2-cycle latency
    zero_data_in = 8'd128;
    frame_len = 20'd4;
    applyStimulus(8'd0, 8'd128, 1'b0);
    checkOutput("lat1", MW'(m_valid), MW'(0));
    applyStimulus(8'd128, 8'd128, 1'b0);
    checkOutput("lat2", MW'(m_valid), MW'(1));
    applyStimulus(8'd255, 8'd128, 1'b0);
    applyStimulus(8'd129, 8'd128, 1'b1);
    idle(1);
    drainCheck("t1");
    checkOutput("t1lane0_0", MW'(outQ[0][15:0]), MW'(16'hFF80));
    checkOutput("t1lane0_1", MW'(outQ[1][15:0]), MW'(16'h0000));
    checkOutput("t1lane0_2", MW'(outQ[2][15:0]), MW'(16'h007F));
    checkOutput("t1lane0_3", MW'(outQ[3][15:0]), MW'(16'h0001));
    clearQ();

    // Continuous input with downstream ready toggling
    zero_data_in = 8'd50;
    frame_len = 20'd6;
    toggleEn = 1'b1;
    for (int k = 0; k < 6; k++) applyStimulus(8'(60 + 10 * k), 8'd50, k == 5);
    idle(1);
    drainCheck("t2");
    clearQ();
    toggleEn = 1'b0;
    @(negedge clk);
    m_ready = 1'b1;
    @(negedge clk);

    // z latched at 10; live value changes mid-frame
    zero_data_in = 8'd10;
    frame_len = 20'd5;
    applyStimulus(8'd20, 8'd10, 1'b0);
    applyStimulus(8'd30, 8'd10, 1'b0);
    zero_data_in = 8'd200;
    frame_len = 20'd1;
    applyStimulus(8'd40, 8'd10, 1'b0);
    applyStimulus(8'd50, 8'd10, 1'b0);
    applyStimulus(8'd60, 8'd10, 1'b1);
    applyStimulus(8'd250, 8'd200, 1'b1);
    idle(1);
    drainCheck("t3");
    clearQ();

    // Back-to-back frames of 3 at full throughput
    zero_data_in = 8'd7;
    frame_len = 20'd3;
    for (int k = 0; k < 6; k++) applyStimulus(8'(100 + k), 8'd7, (k == 2) || (k == 5));
    idle(1);
    drainCheck("t4");
    checkOutput("t4rate", MW'(tsQ[5] - tsQ[0]), MW'(5));
    clearQ();

    // frame_len 0 behaves as 1
    zero_data_in = 8'd0;
    frame_len = 20'd0;
    applyStimulus(8'd33, 8'd0, 1'b1);
    applyStimulus(8'd44, 8'd0, 1'b1);
    idle(1);
    drainCheck("t4z");
    clearQ();

    // Reset with two beats in flight
    m_ready = 1'b0;
    zero_data_in = 8'd3;
    frame_len = 20'd4;
    sendRaw(mkData(8'd9));
    sendRaw(mkData(8'd11));
    s_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("t5Mvalid", MW'(m_valid), MW'(0));
    checkOutput("t5Busy", MW'(busy), MW'(0));
    rst = 1'b0;
    m_ready = 1'b1;
    frame_len = 20'd2;
    @(negedge clk);
    applyStimulus(8'd13, 8'd3, 1'b0);
    applyStimulus(8'd15, 8'd3, 1'b1);
    idle(1);
    drainCheck("t5");
    clearQ();

`ifdef ZERO_MASK_EN
    begin
      logic [DW-1:0] md;
      md = {8'd4, 8'd5, 8'd1, 8'd5, 8'd255, 8'd5, 8'd0, 8'd5};
      zero_data_in = 8'd5;
      frame_len = 20'd1;
      sendRaw(md);
      idle(1);
      checkOutput("t6Valid", MW'(m_valid), MW'(1));
      checkOutput("t6Mask", MW'(m_zero_mask), MW'(8'h55));
      idle(3);
      clearQ();
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
